// File: rtl/vend_dispenser_if.sv
// Request/drive bundle between the vending FSM, the dispenser and the motor driver board.
interface vend_dispenser_if #(
    parameter int STOCK_W = 4
);
    logic               prdA;
    logic               prdB;
    logic               prdC;
    logic               change;
    logic               restock;
    logic               motor_a;
    logic               motor_b;
    logic               motor_c;
    logic               coin_eject;
    logic               busy;
    logic [2:0]         sold_out;
    logic               vend_err;
    logic [STOCK_W-1:0] stock_a;
    logic [STOCK_W-1:0] stock_b;
    logic [STOCK_W-1:0] stock_c;

    modport master (
        output prdA, prdB, prdC, change, restock,
        input  motor_a, motor_b, motor_c, coin_eject, busy, sold_out, vend_err,
        input  stock_a, stock_b, stock_c
    );

    modport slave (
        input  prdA, prdB, prdC, change, restock,
        output motor_a, motor_b, motor_c, coin_eject, busy, sold_out, vend_err,
        output stock_a, stock_b, stock_c
    );
endinterface

// File: rtl/vend_dispenser.sv
// Dispense controller: runs one product motor per accepted vend, then ejects change or a refund,
// while tracking per-slot stock.
module vend_dispenser #(
    parameter int MOTOR_CYCLES  = 8,
    parameter int CHANGE_CYCLES = 4,
    parameter int STOCK_W       = 4,
    parameter int STOCK_INIT    = 4
) (
    input  logic             clk,
    input  logic             rst,
    vend_dispenser_if.slave  bus
);
    localparam int CMAX  = (MOTOR_CYCLES > CHANGE_CYCLES) ? MOTOR_CYCLES : CHANGE_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam logic [CNT_W-1:0]   MOTOR_LD  = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CHANGE_LD = CNT_W'(CHANGE_CYCLES - 1);
    localparam logic [STOCK_W-1:0] SINIT     = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {IDLE, MOTOR, EJECT} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              sel_q, sel_d;
    logic                    chg_q, chg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              motor_q;
    logic                    coin_q;
    logic                    err_q, err_d;
    logic [2:0]              dec;
    logic                    load;
    logic [2:0][STOCK_W-1:0] stock_q;

    logic [2:0] req;
    logic       any_req;
    logic       onehot;
    logic       sel_empty;

    assign req       = {bus.prdC, bus.prdB, bus.prdA};
    assign any_req   = |req;
    assign onehot    = (req == 3'b001) || (req == 3'b010) || (req == 3'b100);
    assign sel_empty = (req[0] && stock_q[0] == '0) ||
                       (req[1] && stock_q[1] == '0) ||
                       (req[2] && stock_q[2] == '0);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        chg_d   = chg_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        dec     = 3'b000;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.restock) begin
                    load  = 1'b1;
                    err_d = any_req;
                end else if (any_req && !onehot) begin
                    err_d = 1'b1;
                end else if (onehot) begin
                    if (sel_empty) begin
                        // Sold-out slot: refund the coins, change bit irrelevant.
                        err_d   = 1'b1;
                        state_d = EJECT;
                        cnt_d   = CHANGE_LD;
                    end else begin
                        sel_d   = req;
                        chg_d   = bus.change;
                        dec     = req;
                        state_d = MOTOR;
                        cnt_d   = MOTOR_LD;
                    end
                end
            end
            MOTOR: begin
                err_d = any_req;
                if (cnt_q == '0) begin
                    if (chg_q) begin
                        state_d = EJECT;
                        cnt_d   = CHANGE_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            EJECT: begin
                err_d = any_req;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'b000;
            chg_q   <= 1'b0;
            cnt_q   <= '0;
            motor_q <= 3'b000;
            coin_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 3; i++) stock_q[i] <= SINIT;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            // Outputs registered from next state so they line up with the state they describe.
            motor_q <= (state_d == MOTOR) ? sel_d : 3'b000;
            coin_q  <= (state_d == EJECT);
            err_q   <= err_d;
            for (int i = 0; i < 3; i++) begin
                if (load)                             stock_q[i] <= SINIT;
                else if (dec[i] && stock_q[i] != '0)  stock_q[i] <= stock_q[i] - STOCK_W'(1);
            end
        end
    end

    assign bus.motor_a    = motor_q[0];
    assign bus.motor_b    = motor_q[1];
    assign bus.motor_c    = motor_q[2];
    assign bus.coin_eject = coin_q;
    assign bus.vend_err   = err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.sold_out   = {stock_q[2] == '0, stock_q[1] == '0, stock_q[0] == '0};
    assign bus.stock_a    = stock_q[0];
    assign bus.stock_b    = stock_q[1];
    assign bus.stock_c    = stock_q[2];
endmodule

// File: tb/tb_vend_dispenser.sv
// Directed plus randomized bench for vend_dispenser, checked against a time-window reference model.
module tb_vend_dispenser;
    localparam int MC = 8;
    localparam int CC = 4;
    localparam int SW = 4;
    localparam int SI = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_dispenser_if #(.STOCK_W(SW)) bus ();

    vend_dispenser #(
        .MOTOR_CYCLES(MC), .CHANGE_CYCLES(CC), .STOCK_W(SW), .STOCK_INIT(SI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: each accepted vend opens a motor window and optionally an eject window, in edge indices.
    int cyc = 0;
    int busy_last = -1;
    int m_first = 1, m_last = 0, prod = 0;
    int e_first = 1, e_last = 0;
    int err_at = -1;
    int stk[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit [2:0] q, input bit ch, input bit rs);
        int n, p;
        n = $countones(q);
        if (r) begin
            busy_last = -1;
            m_first = 1; m_last = 0;
            e_first = 1; e_last = 0;
            err_at = -1;
            for (int i = 0; i < 3; i++) stk[i] = SI;
            return;
        end
        if (cyc > busy_last + 1) begin
            if (rs) begin
                for (int i = 0; i < 3; i++) stk[i] = SI;
                if (n > 0) err_at = cyc;
            end else if (n > 1) begin
                err_at = cyc;
            end else if (n == 1) begin
                p = q[0] ? 0 : (q[1] ? 1 : 2);
                if (stk[p] > 0) begin
                    stk[p]--;
                    prod = p;
                    m_first = cyc; m_last = cyc + MC - 1;
                    if (ch) begin
                        e_first = cyc + MC; e_last = cyc + MC + CC - 1;
                    end
                    busy_last = ch ? cyc + MC + CC - 1 : cyc + MC - 1;
                end else begin
                    err_at = cyc;
                    e_first = cyc; e_last = cyc + CC - 1;
                    busy_last = cyc + CC - 1;
                end
            end
        end else if (n > 0) begin
            err_at = cyc;
        end
    endtask

    task automatic check_all();
        bit mot;
        mot = (cyc >= m_first) && (cyc <= m_last);
        chk("motor_a", bus.motor_a, mot && prod == 0);
        chk("motor_b", bus.motor_b, mot && prod == 1);
        chk("motor_c", bus.motor_c, mot && prod == 2);
        chk("coin_eject", bus.coin_eject, (cyc >= e_first) && (cyc <= e_last));
        chk("busy", bus.busy, cyc <= busy_last);
        chk("vend_err", bus.vend_err, cyc == err_at);
        chk("stock_a", bus.stock_a, stk[0]);
        chk("stock_b", bus.stock_b, stk[1]);
        chk("stock_c", bus.stock_c, stk[2]);
        chk("sold_out", bus.sold_out, {stk[2] == 0, stk[1] == 0, stk[0] == 0});
    endtask

    task automatic step(input bit r, input bit [2:0] q, input bit ch, input bit rs);
        rst         = r;
        bus.prdA    = q[0];
        bus.prdB    = q[1];
        bus.prdC    = q[2];
        bus.change  = ch;
        bus.restock = rs;
        @(posedge clk);
        cyc++;
        model_edge(r, q, ch, rs);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.prdA = 1'b0; bus.prdB = 1'b0; bus.prdC = 1'b0;
        bus.change = 1'b0; bus.restock = 1'b0;
        for (int i = 0; i < 3; i++) stk[i] = SI;

        step(1'b1, 3'b000, 1'b0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 1'b0);
        chk("reset_sold_out", bus.sold_out, 3'b000);
        chk("reset_stock_a", bus.stock_a, SI);
        idle(2);

        // Vend A without change, then B with change.
        step(1'b0, 3'b001, 1'b0, 1'b0);
        idle(10);
        chk("vendA_stock", bus.stock_a, 3);
        step(1'b0, 3'b010, 1'b1, 1'b0);
        idle(14);
        chk("vendB_stock", bus.stock_b, 3);

        // Drain C, then a sold-out refund.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 3'b100, 1'b0, 1'b0);
            idle(9);
        end
        chk("drainC_stock", bus.stock_c, 0);
        chk("drainC_sold_out", bus.sold_out, 3'b100);
        step(1'b0, 3'b100, 1'b1, 1'b0);
        idle(6);
        chk("refund_no_wrap", bus.stock_c, 0);

        // Multi-hot request, then a request dropped during motor_c.
        step(1'b0, 3'b000, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 3'b011, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 3'b100, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 3'b001, 1'b0, 1'b0);
        idle(8);

        // Restock beats a same-cycle request; restock while busy is ignored.
        step(1'b0, 3'b010, 1'b0, 1'b0);
        idle(9);
        step(1'b0, 3'b001, 1'b0, 1'b1);
        idle(2);
        chk("restock_b", bus.stock_b, SI);
        step(1'b0, 3'b010, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 3'b000, 1'b0, 1'b1);
        idle(8);
        chk("restock_busy_ignored", bus.stock_b, SI - 1);

        // Reset in the middle of a motor run.
        step(1'b0, 3'b001, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 3'b000, 1'b0, 1'b0);
        chk("rst_mid_motor", bus.motor_a, 1'b0);
        chk("rst_mid_busy", bus.busy, 1'b0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, ch, rs;
            bit [2:0] q;
            r  = ($urandom % 97) == 0;
            rs = ($urandom % 20) == 0;
            ch = $urandom % 2;
            q  = '0;
            for (int j = 0; j < 3; j++) q[j] = ($urandom % 7) == 0;
            step(r, q, ch, rs);
        end
        idle(15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_dispenser.md
# vend_dispenser

Dispense controller directly downstream of the vending FSM. Consumes its registered one-cycle `prdA`/`prdB`/`prdC`/`change` pulses, drives one product motor for a fixed number of cycles, then pulses the coin ejector when change is owed. Tracks per-product stock, flags sold-out slots and reports dropped or illegal requests. Outputs go to the motor/solenoid driver board.

## Interface
- `MOTOR_CYCLES`, 8: cycles a motor output stays high per vend; legal range is 1 or more.
- `CHANGE_CYCLES`, 4: cycles `coin_eject` stays high per change/refund; legal range is 1 or more.
- `STOCK_W`, 4: width of each stock counter.
- `STOCK_INIT`, 4: stock loaded at reset and on restock; must be no more than 2^STOCK_W−1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `prdA` in 1: vend request, product A (one-cycle pulse).
- `prdB` in 1: vend request, product B.
- `prdC` in 1: vend request, product C.
- `change` in 1: change owed; qualifies the product pulse in the same cycle.
- `restock` in 1: reload all stock counters to `STOCK_INIT`.
- `motor_a` out 1: product A motor drive.
- `motor_b` out 1: product B motor drive.
- `motor_c` out 1: product C motor drive.
- `coin_eject` out 1: coin ejector solenoid.
- `busy` out 1: high whenever state ≠ IDLE.
- `sold_out` out 3: bit0/1/2 is high when stock A/B/C equals 0.
- `vend_err` out 1: one-cycle pulse on a rejected request.
- `stock_a` out STOCK_W: product A stock count.
- `stock_b` out STOCK_W: product B stock count.
- `stock_c` out STOCK_W: product C stock count.

## Operation
- **States:** IDLE, MOTOR, EJECT. All outputs are registered, except `busy` and `sold_out`, which are decoded directly from registers.
- **Request:** the OR of `prdA`, `prdB` and `prdC`. **One-hot request:** exactly one of the three is high.
- **IDLE, no request, no restock:** the block holds.
- **IDLE, `restock` high:**
  - All stocks load `STOCK_INIT` at the next edge.
  - Restock has priority. A request in the same cycle is dropped and `vend_err` pulses.
- **IDLE, multi-hot request:** `vend_err` pulses, the FSM stays in IDLE and stock is unchanged.
- **IDLE, one-hot request, selected stock > 0:**
  - Latch the product and the `change` bit.
  - Decrement that stock by 1.
  - Go to MOTOR and load the cycle counter with `MOTOR_CYCLES`−1.
- **IDLE, one-hot request, selected stock = 0 (sold out):**
  - `vend_err` pulses and no motor runs.
  - Go to EJECT (refund), regardless of `change`.
- **MOTOR:**
  - The selected `motor_x` is high and the counter decrements.
  - At counter 0: if the latched change bit is set, go to EJECT with counter `CHANGE_CYCLES`−1; otherwise go to IDLE.
- **EJECT:** `coin_eject` is high and the counter decrements. At counter 0, go to IDLE.
- **Request while `busy`:** dropped, `vend_err` pulses, and state, stock and latches are unaffected.
- **`restock` while `busy`:** ignored.
- **Stock counters** never wrap. They decrement only when nonzero and never increment except by restock load.
- **Reset:**
  - State returns to IDLE.
  - All motor, `coin_eject` and `vend_err` outputs are 0.
  - Stocks load `STOCK_INIT`, so `sold_out` is 0 when `STOCK_INIT` > 0.
  - The latched product, change bit and counter clear.
- **Reset mid-MOTOR or mid-EJECT:** outputs drop at that edge. The decremented stock is overwritten by `STOCK_INIT`.

## Timing
- The request is sampled at edge N.
- `motor_x` is high during cycles N+1 … N+`MOTOR_CYCLES`, and `busy` is high from N+1.
- With change, `coin_eject` is high during N+`MOTOR_CYCLES`+1 … N+`MOTOR_CYCLES`+`CHANGE_CYCLES`.
- `busy` falls after the last active cycle, so the next request is accepted at the first edge where `busy` = 0.
- For a sold-out refund, `vend_err` and `coin_eject` both rise at N+1. `coin_eject` stays high for `CHANGE_CYCLES` cycles.
- `vend_err` is exactly one cycle wide and is asserted in the cycle after the offending sample.
- Stock decrement and `sold_out` update are visible from N+1.
- At most one motor output is ever high, and no motor output is ever high together with `coin_eject`.

## Test plan
- **Reset, then vend A:** reset with default parameters, then pulse `prdA` for 1 cycle with `change`=0. Required: `motor_a` high for exactly 8 cycles, `stock_a` goes 4→3, no `coin_eject`, `busy` high for 8 cycles.
- **Vend B with change:** pulse `prdB` with `change`=1. Required: `motor_b` high for 8 cycles, then `coin_eject` high for 4 cycles, `busy` high for 12 cycles, `stock_b` = 3.
- **Sold-out refund:** vend C 4 times, check `stock_c`=0 and `sold_out`=3'b100. Pulse `prdC` a 5th time. Required: `vend_err` pulses once, `coin_eject` high for 4 cycles, no `motor_c`, and `stock_c` stays 0 (no wrap to 15).
- **Illegal and dropped requests:** pulse `prdA`+`prdB` together, then pulse `prdA` during an active `motor_c`. Required: one `vend_err` pulse each, and stocks and motor timing unchanged.
- **Restock and reset priority:**
  - `restock` plus `prdA` in IDLE: all stocks = 4, `vend_err` pulses, no motor.
  - `restock` during MOTOR: ignored.
  - Assert `rst` at motor cycle 3: `motor_x` is 0 at the next edge, stocks = 4, `busy` = 0.
